// File: rtl/pytxarqbufctrl.sv
// TX payload buffer controller: per-LT ping-pong half, SEQN and ARQ state, packet-start
// decision (new / retransmit / NULL) and serialisation of payload bits from the buffer RAM.
module pytxarqbufctrl #(
    parameter int  NLT = 7,
    parameter int  AW  = 8,
    parameter int  DW  = 32,
    localparam int BW  = $clog2(DW)
) (
    input  logic               clk_6M,
    input  logic               rstz,
    input  logic [2:0]         ms_lt_addr,
    input  logic               tx_packet_st_p,
    input  logic               rx_hdr_p,
    input  logic               dec_hecgood,
    input  logic               dec_arqn,
    input  logic               dec_flow,
    input  logic [2:0]         regi_lt,
    input  logic               regi_datready_p,
    input  logic               regi_flush_p,
    input  logic               py_datperiod,
    input  logic [AW+BW-1:0]   pybitcount,
    input  logic [DW-1:0]      buf_rd_data,
    output logic [AW+3:0]      buf_rd_addr,
    output logic               lnctrl_txpybitin,
    output logic               tx_seqn,
    output logic               sendnewpy,
    output logic               tx_retx,
    output logic               tx_null,
    output logic               newpy_int,
    output logic [2:0]         newpy_lt,
    output logic               regi_ovf,
    output logic [NLT-1:0]     regi_txs1a,
    output logic [NLT-1:0]     regi_txpending,
    output logic [NLT-1:0]     regi_flowstop
);

    logic [NLT-1:0] seqn, busy;
    logic [NLT-1:0] s1a_d, seqn_d, busy_d, pend_d, flow_d;

    // View of the LT addressed by the current slot and by the MCU command.
    logic ms_ok, cur_s1a, cur_seqn, cur_busy, cur_pend, cur_flow;
    logic regi_ok, regi_pend;

    logic swap, retx, ack, ovf;
    logic [BW-1:0] idx_q;
    logic          dp_q;

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        ms_ok     = 1'b0;
        cur_s1a   = 1'b0;
        cur_seqn  = 1'b0;
        cur_busy  = 1'b0;
        cur_pend  = 1'b0;
        cur_flow  = 1'b0;
        regi_ok   = 1'b0;
        regi_pend = 1'b0;
        for (int i = 0; i < NLT; i++) begin
            if (ms_lt_addr == 3'(i + 1)) begin
                ms_ok    = 1'b1;
                cur_s1a  = regi_txs1a[i];
                cur_seqn = seqn[i];
                cur_busy = busy[i];
                cur_pend = regi_txpending[i];
                cur_flow = regi_flowstop[i];
            end
            if (regi_lt == 3'(i + 1)) begin
                regi_ok   = 1'b1;
                regi_pend = regi_txpending[i];
            end
        end
    end

    assign swap = tx_packet_st_p && ms_ok && !cur_flow && !cur_busy && cur_pend;
    assign retx = tx_packet_st_p && ms_ok && !cur_flow && cur_busy;

    // A busy LT cannot swap in the same cycle, so an ack never collides with a swap.
    assign ack = rx_hdr_p && dec_hecgood && dec_arqn && ms_ok && cur_busy &&
                 !(regi_flush_p && regi_lt == ms_lt_addr);

    // A datready that lands on the pending payload being consumed this cycle is not an overflow.
    assign ovf = regi_datready_p && regi_ok && regi_pend && !regi_flush_p &&
                 !(swap && regi_lt == ms_lt_addr);

    always_comb begin
        s1a_d  = regi_txs1a;
        seqn_d = seqn;
        busy_d = busy;
        pend_d = regi_txpending;
        flow_d = regi_flowstop;
        for (int i = 0; i < NLT; i++) begin
            if (ms_lt_addr == 3'(i + 1)) begin
                if (swap) begin
                    s1a_d[i]  = !regi_txs1a[i];
                    seqn_d[i] = !seqn[i];
                    pend_d[i] = 1'b0;
                    busy_d[i] = 1'b1;
                end
                if (rx_hdr_p && dec_hecgood) begin
                    flow_d[i] = !dec_flow;
                    if (dec_arqn && busy[i])
                        busy_d[i] = 1'b0;
                end
            end
            if (regi_lt == 3'(i + 1)) begin
                if (regi_datready_p)
                    pend_d[i] = 1'b1;
                if (regi_flush_p) begin
                    busy_d[i] = 1'b0;
                    pend_d[i] = 1'b0;
                    flow_d[i] = 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            regi_txs1a     <= '0;
            seqn           <= '0;
            busy           <= '0;
            regi_txpending <= '0;
            regi_flowstop  <= '0;
            sendnewpy      <= 1'b0;
            tx_retx        <= 1'b0;
            tx_null        <= 1'b0;
            newpy_int      <= 1'b0;
            newpy_lt       <= 3'd0;
            regi_ovf       <= 1'b0;
            idx_q          <= '0;
            dp_q           <= 1'b0;
        end else begin
            regi_txs1a     <= s1a_d;
            seqn           <= seqn_d;
            busy           <= busy_d;
            regi_txpending <= pend_d;
            regi_flowstop  <= flow_d;
            sendnewpy      <= swap;
            tx_retx        <= retx;
            tx_null        <= tx_packet_st_p && !swap && !retx;
            newpy_int      <= ack;
            if (ack)
                newpy_lt <= ms_lt_addr;
            regi_ovf       <= ovf;
            idx_q          <= pybitcount[BW-1:0];
            dp_q           <= py_datperiod;
        end
    end

    assign tx_seqn          = cur_seqn;
    assign buf_rd_addr      = {ms_lt_addr, cur_s1a, pybitcount[AW+BW-1:BW]};
    assign lnctrl_txpybitin = dp_q & buf_rd_data[idx_q];

endmodule

// File: doc/pytxarqbufctrl.md
# pytxarqbufctrl

Parametrised TX payload buffer controller for up to NLT logical transports in the baseband link controller. Each LT_ADDR has its own ping-pong payload half, SEQN bit, outstanding-ACK flag, pending-data flag and remote-flow state. At every TX packet start the block decides between new payload, retransmission and NULL. It also serialises payload bits from an external synchronous buffer RAM to the packet encoder.

## Interface
Parameters:
- NLT, 7, number of logical transports served (LT_ADDR 1..NLT; legal 1..7).
- AW, 8, word address width within one buffer half.
- DW, 32, buffer word width; power of two ≥ 8. BW = log2(DW).

Ports:
- clk_6M  in  1  6 MHz clock.
- rstz  in  1  asynchronous active-low reset.
- ms_lt_addr  in  3  LT_ADDR of the current TX/RX slot.
- tx_packet_st_p  in  1  one-cycle pulse at TX packet start.
- rx_hdr_p  in  1  one-cycle pulse when the received header is decoded.
- dec_hecgood, dec_arqn, dec_flow  in  1 each  received HEC result, ARQN and FLOW.
- regi_lt  in  3  LT_ADDR targeted by an MCU command.
- regi_datready_p  in  1  MCU has written a new payload into the inactive half of regi_lt.
- regi_flush_p  in  1  flush all state of regi_lt.
- py_datperiod  in  1  payload bits are being encoded.
- pybitcount  in  AW+BW  payload bit index.
- buf_rd_data  in  DW  RAM read data, valid one cycle after buf_rd_addr.
- buf_rd_addr  out  3+1+AW  {ms_lt_addr, active half, pybitcount[AW+BW-1:BW]}.
- lnctrl_txpybitin  out  1  serial payload bit.
- tx_seqn  out  1  SEQN of ms_lt_addr.
- sendnewpy, tx_retx, tx_null  out  1 each  registered one-cycle TX decision pulses.
- newpy_int  out  1  one-cycle pulse: payload acked, the inactive half is free.
- newpy_lt  out  3  LT_ADDR qualifying newpy_int.
- regi_ovf  out  1  one-cycle pulse: datready while already pending.
- regi_txs1a, regi_txpending, regi_flowstop  out  NLT each  per-LT active half / pending / remote STOP.

## Operation
- Per-LT registers, all reset to 0: s1a, seqn, busy (outstanding unacked payload), pending, flowstop.
- LT_ADDR 0 or > NLT is ignored by every event. For TX starts with such an LT_ADDR, tx_null pulses.
- TX decision at tx_packet_st_p for LT L, in priority order:
  1. flowstop[L] → tx_null; no state change.
  2. busy[L] → tx_retx; no state change.
  3. pending[L] → s1a toggles, seqn toggles, pending←0, busy←1, sendnewpy.
  4. Otherwise → tx_null.
- RX header at rx_hdr_p with dec_hecgood=1 for L:
  - flowstop[L] ← !dec_flow.
  - If dec_arqn=1 and busy[L] → busy←0, newpy_int pulses, newpy_lt=L.
  - When dec_hecgood=0 the header is ignored entirely.
- regi_datready_p: pending[regi_lt]←1. If pending is already 1, regi_ovf pulses and state is unchanged.
- regi_flush_p: busy, pending and flowstop of regi_lt are cleared. s1a and seqn are kept.
- Read path:
  - buf_rd_addr is combinational from the current registers.
  - pybitcount[BW-1:0] is delayed one cycle.
  - lnctrl_txpybitin = buf_rd_data[delayed index] when py_datperiod was high in the previous cycle, else 0.
- Outputs regi_txs1a, regi_txpending, regi_flowstop are direct register views. Bit i-1 corresponds to LT i.

## Timing
- Decision pulses and newpy_int assert in the cycle after the triggering pulse and last exactly one cycle.
- The state update is visible on tx_seqn / buf_rd_addr in the same cycle as the decision pulse.
- Serial bit latency from pybitcount is one clock, matching the RAM read latency.
- Simultaneous events:
  - tx_packet_st_p and rx_hdr_p: the TX decision uses pre-cycle state. An ack for the same LT that swapped in that cycle is dropped; busy stays 1.
  - tx_packet_st_p and regi_datready_p for the same LT: the decision sees the old pending; pending is set afterwards. If the TX consumed the old pending, the new one survives.
  - regi_flush_p and regi_datready_p in the same cycle: flush wins.
  - regi_flush_p and a TX/RX event on the same LT: flush wins; no pulse from the other event except its decision output.
- Reset mid-packet: every register and output returns to 0 asynchronously. No pulse is emitted on release.

## Test plan
- Reset, then datready LT=3, TX start LT=3 → sendnewpy, regi_txs1a[2]=1, tx_seqn=1. A second TX start without ack → tx_retx, seqn stays 1.
- Header LT=3 with hecgood=1, arqn=1 → newpy_int with newpy_lt=3, busy cleared. Next TX start LT=3 with no pending → tx_null.
- Header LT=5 with flow=0, then datready LT=5 and TX start LT=5 → tx_null, pending stays 1. Header flow=1, then TX start → sendnewpy.
- Two datready LT=1 without TX → regi_ovf pulse on the second one, pending=1.
- Same-cycle TX start and datready LT=2 with pending=1 → sendnewpy and pending=1 afterwards. Same-cycle flush and datready → pending=0.
- NLT=2, DW=16: TX start LT=4 → tx_null. With buf_rd_data=16'h8001, the bit stream for index 0 then index 15 → 1 then 1, each one cycle after the index is applied.
